// File: rtl/int_res_mem_arbiter.sv
// int_res_mem_arbiter
//   Round-robin arbiter and access sequencer for the 4-bank intermediate-result
//   memory. A granted request is latched, range-checked, and decoded from a flat
//   word address into bank select plus bank-local address. Double-width (2 word)
//   accesses become two back-to-back single-word accesses. The upper half is at
//   addr and the lower half is at addr+1.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_write    per-requester 1 = write, 0 = read
//   req_width    per-requester 0 = single, 1 = double width
//   req_addr     per-requester flat word address (slice k)
//   req_wdata    per-requester write data (slice k); single uses low N_STO bits
//   grant        one-cycle pulse, request k accepted (combinational in IDLE)
//   rsp_valid    one-cycle pulse, rsp_rdata valid for requester k
//   rsp_rdata    shared read-data bus, held until the next response
//   err          one-cycle pulse with grant, request out of range
//   mem_en       bank chip enables, zero or one-hot
//   mem_we       write enable for the enabled bank
//   mem_addr     bank-local word address
//   mem_wdata    write word
//   mem_rdata    all banks' read data, valid the cycle after mem_en
module int_res_mem_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned BANK_WORDS  = 14336,
    parameter int unsigned NUM_BANKS   = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BANK_ADDR_W = 14,
    parameter int unsigned N_STO       = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ-1:0]            req_width,
    input  logic [N_REQ*ADDR_W-1:0]     req_addr,
    input  logic [N_REQ*2*N_STO-1:0]    req_wdata,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [2*N_STO-1:0]          rsp_rdata,
    output logic                        err,
    output logic [NUM_BANKS-1:0]        mem_en,
    output logic                        mem_we,
    output logic [BANK_ADDR_W-1:0]      mem_addr,
    output logic [N_STO-1:0]            mem_wdata,
    input  logic [NUM_BANKS*N_STO-1:0]  mem_rdata
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned IW1    = IDX_W + 1;
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned LAST_W = NUM_BANKS * BANK_WORDS - 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC0 = 3'd1;
    localparam logic [2:0] ACC1 = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    logic [2:0]           state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 write_q;
    logic                 double_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [2*N_STO-1:0]   wdata_q;
    logic [BANK_W-1:0]    acc_bank_q;
    logic [N_STO-1:0]     word0_q;
    logic [2*N_STO-1:0]   rsp_rdata_q;

    // ---------------- arbitration ----------------
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IW1-1:0]       cand_sum;
    logic [IDX_W-1:0]     cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + IW1'(i);
            if (cand_sum >= IW1'(N_REQ))
                cand_sum = cand_sum - IW1'(N_REQ);
            cand = cand_sum[IDX_W-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic                 sel_write;
    logic                 sel_double;
    logic [ADDR_W-1:0]    sel_addr;
    logic [2*N_STO-1:0]   sel_wdata;
    logic [AW1-1:0]       sel_last;
    logic                 sel_oor;
    logic                 arb_fire;

    always_comb begin
        sel_write  = req_write[win_idx];
        sel_double = req_width[win_idx];
        sel_addr   = req_addr[win_idx*ADDR_W +: ADDR_W];
        sel_wdata  = req_wdata[win_idx*2*N_STO +: 2*N_STO];
        sel_last   = {1'b0, sel_addr} + AW1'(sel_double);
        sel_oor    = sel_last > AW1'(LAST_W);
        // Gated with rst_n so grant/err are quiet while reset is held.
        arb_fire   = rst_n && (state_q == IDLE) && win_found;
    end

    always_comb begin
        grant = '0;
        if (arb_fire)
            grant[win_idx] = 1'b1;
        err = arb_fire && sel_oor;
    end

    // ---------------- address decode (compare chain) ----------------
    logic                 acc_active;
    logic [AW1-1:0]       cur_word;
    logic [AW1-1:0]       cur_base;
    logic [BANK_W-1:0]    cur_bank;
    logic [AW1-1:0]       cur_off;

    always_comb begin
        acc_active = (state_q == ACC0) || (state_q == ACC1);
        cur_word   = {1'b0, addr_q} + AW1'(state_q == ACC1);
        cur_bank   = '0;
        cur_base   = '0;
        for (int unsigned b = 1; b < NUM_BANKS; b++) begin
            if (cur_word >= AW1'(b * BANK_WORDS)) begin
                cur_bank = BANK_W'(b);
                cur_base = AW1'(b * BANK_WORDS);
            end
        end
        cur_off = cur_word - cur_base;
    end

    always_comb begin
        mem_en    = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc_active) begin
            mem_en[cur_bank] = 1'b1;
            mem_we           = write_q;
            mem_addr         = cur_off[BANK_ADDR_W-1:0];
            if (write_q)
                mem_wdata = (state_q == ACC0 && double_q) ? wdata_q[2*N_STO-1:N_STO]
                                                          : wdata_q[N_STO-1:0];
        end
    end

    // Read word from the bank that was enabled in the previous cycle.
    logic [N_STO-1:0] rd_word;
    always_comb rd_word = mem_rdata[acc_bank_q*N_STO +: N_STO];

    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP)
            rsp_valid[idx_q] = 1'b1;
        rsp_rdata = rsp_rdata_q;
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            double_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            acc_bank_q  <= '0;
            word0_q     <= '0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        ptr_q    <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                        idx_q    <= win_idx;
                        write_q  <= sel_write;
                        double_q <= sel_double;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        if (!sel_oor) begin
                            state_q <= ACC0;
                        end else if (!sel_write) begin
                            rsp_rdata_q <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                ACC0: begin
                    acc_bank_q <= cur_bank;
                    if (double_q)
                        state_q <= ACC1;
                    else if (write_q)
                        state_q <= IDLE;
                    else
                        state_q <= WAIT;
                end
                ACC1: begin
                    acc_bank_q <= cur_bank;
                    if (!write_q)
                        word0_q <= rd_word;
                    state_q <= write_q ? IDLE : WAIT;
                end
                WAIT: begin
                    rsp_rdata_q <= double_q ? {word0_q, rd_word}
                                            : {{N_STO{rd_word[N_STO-1]}}, rd_word};
                    state_q <= RESP;
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_res_mem_arbiter.sv
// Directed table-driven bench for int_res_mem_arbiter with a behavioural
// 4-bank synchronous-read memory attached.
module tb_int_res_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid, req_write, req_width;
    logic [63:0]   req_addr;
    logic [119:0]  req_wdata;
    logic [3:0]    grant, rsp_valid;
    logic [29:0]   rsp_rdata;
    logic          err;
    logic [3:0]    mem_en;
    logic          mem_we;
    logic [13:0]   mem_addr;
    logic [14:0]   mem_wdata;
    logic [59:0]   mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    int_res_mem_arbiter #(
        .N_REQ(4), .BANK_WORDS(14336), .NUM_BANKS(4),
        .ADDR_W(16), .BANK_ADDR_W(14), .N_STO(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural banks: registered read, write-through on mem_we.
    logic [14:0] mem [0:3][0:14335];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_en[b]) begin
                if (mem_we) mem[b][mem_addr] <= mem_wdata;
                else        mem_rdata[b*15 +: 15] <= mem[b][mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // mem_en zero-or-one-hot and mem_we only with an enable, every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_en_onehot0", 32'($onehot0(mem_en)), 32'd1);
            chk("mem_we_gated", 32'(mem_we && (mem_en == 4'd0)), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int          idx;
        bit          wr;
        bit          dbl;
        logic [15:0] addr;
        logic [29:0] wdata;
        bit          err;
        int          b0;
        int          a0;
        logic [14:0] w0;
        int          b1;
        int          a1;
        logic [14:0] w1;
        logic [29:0] rd;
    } vec_t;

    vec_t vecs[17];

    task automatic set_req(input int k, input bit wr, input bit dbl,
                           input logic [15:0] a, input logic [29:0] d);
        req_write[k] = wr;
        req_width[k] = dbl;
        req_addr[k*16 +: 16] = a;
        req_wdata[k*30 +: 30] = d;
    endtask

    task automatic chk_acc(input int b, input int a, input logic [14:0] w, input bit wr);
        chk("acc_mem_en", 32'(mem_en), 32'(4'b0001 << b));
        chk("acc_mem_we", 32'(mem_we), 32'(wr));
        chk("acc_mem_addr", 32'(mem_addr), 32'(a));
        if (wr) chk("acc_mem_wdata", 32'(mem_wdata), 32'(w));
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        req_valid = '0;
        set_req(v.idx, v.wr, v.dbl, v.addr, v.wdata);
        req_valid[v.idx] = 1'b1;
        #2;
        chk("grant", 32'(grant), 32'(4'b0001 << v.idx));
        chk("err", 32'(err), 32'(v.err));
        @(negedge clk); req_valid = '0; #2;
        if (v.err) begin
            chk("oor_mem_en", 32'(mem_en), 32'd0);
            if (!v.wr) begin
                chk("oor_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << v.idx));
                chk("oor_rsp_rdata", 32'(rsp_rdata), 32'd0);
            end
        end else begin
            chk_acc(v.b0, v.a0, v.w0, v.wr);
            if (v.dbl) begin
                @(negedge clk); #2;
                chk_acc(v.b1, v.a1, v.w1, v.wr);
            end
            if (!v.wr) begin
                @(negedge clk); #2;
                chk("rsp_early", 32'(rsp_valid), 32'd0);
                @(negedge clk); #2;
                chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << v.idx));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(v.rd));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 1, 0, 16'd14336, 30'h4ABC,     0, 1, 0,     15'h4ABC, 0, 0,     15'h0,    30'h0};
        vecs[1]  = '{0, 0, 0, 16'd14336, 30'h0,        0, 1, 0,     15'h0,    0, 0,     15'h0,    30'h3FFFCABC};
        vecs[2]  = '{1, 1, 1, 16'd14335, 30'h12345678, 0, 0, 14335, 15'h2468, 1, 0,     15'h5678, 30'h0};
        vecs[3]  = '{2, 0, 1, 16'd14335, 30'h0,        0, 0, 14335, 15'h0,    1, 0,     15'h0,    30'h12345678};
        vecs[4]  = '{3, 1, 0, 16'd57343, 30'h1234,     0, 3, 14335, 15'h1234, 0, 0,     15'h0,    30'h0};
        vecs[5]  = '{0, 1, 0, 16'd57342, 30'h7FFF,     0, 3, 14334, 15'h7FFF, 0, 0,     15'h0,    30'h0};
        vecs[6]  = '{1, 0, 1, 16'd57342, 30'h0,        0, 3, 14334, 15'h0,    3, 14335, 15'h0,    30'h3FFF9234};
        vecs[7]  = '{3, 0, 1, 16'd57343, 30'h0,        1, 0, 0,     15'h0,    0, 0,     15'h0,    30'h0};
        vecs[8]  = '{3, 0, 0, 16'd57343, 30'h0,        0, 3, 14335, 15'h0,    0, 0,     15'h0,    30'h1234};
        vecs[9]  = '{1, 1, 0, 16'd57344, 30'h1111,     1, 0, 0,     15'h0,    0, 0,     15'h0,    30'h0};
        vecs[10] = '{2, 1, 1, 16'd57343, 30'h2222,     1, 0, 0,     15'h0,    0, 0,     15'h0,    30'h0};
        vecs[11] = '{0, 1, 0, 16'd43007, 30'h3FFF8123, 0, 2, 14335, 15'h0123, 0, 0,     15'h0,    30'h0};
        vecs[12] = '{2, 0, 0, 16'd43007, 30'h0,        0, 2, 14335, 15'h0,    0, 0,     15'h0,    30'h123};
        vecs[13] = '{3, 1, 1, 16'd28671, 30'h2AAAAAAA, 0, 1, 14335, 15'h5555, 2, 0,     15'h2AAA, 30'h0};
        vecs[14] = '{1, 0, 1, 16'd28671, 30'h0,        0, 1, 14335, 15'h0,    2, 0,     15'h0,    30'h2AAAAAAA};
        vecs[15] = '{2, 1, 0, 16'd5,     30'h0111,     0, 0, 5,     15'h0111, 0, 0,     15'h0,    30'h0};
        vecs[16] = '{2, 1, 0, 16'd6,     30'h7000,     0, 0, 6,     15'h7000, 0, 0,     15'h0,    30'h0};

        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_width = '0;
        req_addr = '0;  req_wdata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", 32'({grant, rsp_valid, err, mem_en, mem_we}), 32'd0);
        chk("reset_rdata", 32'({mem_addr, mem_wdata}), 32'd0);
        @(negedge clk); rst_n = 1'b1; #2;
        chk("idle_outputs", 32'({grant, rsp_valid, err, mem_en, mem_we}), 32'd0);
        chk("idle_rsp_rdata", 32'(rsp_rdata), 32'd0);

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Reset in ACC1 of a double read: outputs clear at once, no response.
        @(negedge clk);
        set_req(3, 0, 1, 16'd14335, 30'h0);
        req_valid = 4'b1000;
        #2;
        chk("rst_seq_grant", 32'(grant), 32'b1000);
        @(negedge clk); req_valid = '0;
        @(negedge clk); #2;
        chk("rst_seq_acc1", 32'(mem_en), 32'b0010);
        set_req(1, 0, 0, 16'd5, 30'h0);
        set_req(2, 0, 0, 16'd6, 30'h0);
        req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({grant, rsp_valid, err, mem_en, mem_we}), 32'd0);
        chk("rst_mid_addr", 32'({mem_addr, mem_wdata}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #2;
            chk("rst_hold_quiet", 32'({grant, rsp_valid}), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1; #2;
        chk("rst_first_grant", 32'(grant), 32'b0010);
        @(negedge clk); req_valid = 4'b0100; #2;
        chk("rst_no_grant_busy", 32'(grant), 32'd0);
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk("rst_rsp_owner", 32'(rsp_valid), 32'b0010);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h111);
        @(negedge clk); #2;
        chk("rst_second_grant", 32'(grant), 32'b0100);
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk);

        // Round robin after reset: all four held, single reads -> 0,1,2,3,0 every 4 cycles.
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 0, 0, 16'd5, 30'h0);
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            chk("rr_grant", 32'(grant), (c % 4 == 0) ? 32'(4'b0001 << ((c / 4) % 4)) : 32'd0);
        end
        @(negedge clk); req_valid = '0;
        repeat (6) @(negedge clk);

        // Back-to-back: req2 held high, address changed after the first grant.
        set_req(2, 0, 0, 16'd5, 30'h0);
        req_valid = 4'b0100;
        #2;
        chk("b2b_grant0", 32'(grant), 32'b0100);
        @(negedge clk); set_req(2, 0, 0, 16'd6, 30'h0); #2;
        chk("b2b_busy1", 32'(grant), 32'd0);
        @(negedge clk); #2;
        chk("b2b_busy2", 32'(grant), 32'd0);
        @(negedge clk); #2;
        chk("b2b_busy3", 32'(grant), 32'd0);
        chk("b2b_rsp0_valid", 32'(rsp_valid), 32'b0100);
        chk("b2b_rsp0_rdata", 32'(rsp_rdata), 32'h111);
        @(negedge clk); #2;
        chk("b2b_grant1", 32'(grant), 32'b0100);
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        @(negedge clk); #2;
        chk("b2b_rsp1_valid", 32'(rsp_valid), 32'b0100);
        chk("b2b_rsp1_rdata", 32'(rsp_rdata), 32'h3FFFF000);
        @(negedge clk); #2;
        chk("b2b_rdata_hold", 32'(rsp_rdata), 32'h3FFFF000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
